// File: rtl/event_encoder.sv
// Registered 8-to-3 event encoder: rising edges on d are queued as sticky pending
// bits and drained one index per cycle over valid/ready. Define RR_ARB_EN for round-robin selection.
module event_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         ready,
  output logic [W-1:0] i,
  output logic         valid,
  output logic         busy,
  output logic         ovf
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   d_q;
  logic [N-1:0]   pending;
  logic [N-1:0]   rise;
  logic [N-1:0]   load_mask;
  logic [W-1:0]   sel;
  logic           load;
  logic           has_pend;

  assign rise     = d & ~d_q;
  assign has_pend = |pending;
  assign valid    = (state == HOLD);
  assign busy     = has_pend | valid;

`ifdef RR_ARB_EN
  logic [W-1:0] last_loaded;
  logic [W-1:0] cand;

  // Walk offsets from far to near so the nearest set bit after last_loaded wins;
  // W-bit wraparound gives the mod-N search because N == 2**W.
  always_comb begin
    sel  = '0;
    cand = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = last_loaded + W'(1) + W'(off);
      if (pending[cand]) sel = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last_loaded <= W'(N - 1);
    else if (load) last_loaded <= sel;
  end
`else
  // Ascending scan: the last match is the highest set index.
  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (pending[k]) sel = W'(k);
    end
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (has_pend) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (has_pend) load      = 1'b1;
          else          state_nxt = IDLE;
        end
      end
    endcase
    load_mask = load ? (N'(1) << sel) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      d_q     <= '0;
      pending <= '0;
      i       <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      d_q     <= d;
      // A rise on the bit being loaded re-sets it, so that new event is kept.
      pending <= (pending & ~load_mask) | rise;
      if (load) i <= sel;
      if (|(rise & pending & ~load_mask)) ovf <= 1'b1;
    end
  end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Registered 8-to-3 event encoder; the inverse of the 3-to-8 decoder.
- Detects rising edges on eight request lines and queues each as a sticky pending bit.
- Emits one 3-bit index per event on a valid/ready output, draining pending events in priority order.
- Sits between discrete lab inputs (buttons, comparators) and downstream logic that consumes a binary code.

Parameters:
- N, 8, number of request lines; must equal 2**W.
- W, 3, width of the output code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  N  request lines; a 0->1 transition on d[k] is one event for index k.
- ready  input  1  consumer accepts i this cycle when ready=1 and valid=1.
- i  output  W  encoded index of the presented event.
- valid  output  1  i holds a presented event.
- busy  output  1  equals (|pending) | valid.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset is synchronous, active-high, and sampled on clk rising edge. It overrides all other activity, including reset during HOLD.
- Reset values: i=0, valid=0, ovf=0, busy=0, pending=0, d_q=0, state=IDLE. Any event in flight is discarded.
- Edge detect: d_q <= d every cycle; rise = d & ~d_q.
  - d held high produces exactly one event.
  - d already high when rst deasserts counts as an event, because d_q resets to 0.
- Pending update each edge: pending <= (pending & ~load_mask) | rise.
  - load_mask is the one-hot bit of the index being loaded into i this edge, or 0 if nothing is loaded.
  - If a bit is cleared by a load and set by a rise on the same edge, the set wins: the new event is kept.
- Overflow:
  - ovf <= 1 if (rise & pending & ~load_mask) != 0, i.e. a rise on an index already pending and not being loaded this edge.
  - The duplicate event is dropped, so one code is emitted for that index.
  - ovf is cleared only by rst.
- Selection (fixed priority): the highest set index of pending. Same-cycle rises are not visible to selection.
- Handshake:
  - Transfer occurs on an edge where valid=1 and ready=1.
  - While valid=1 and ready=0, i is held stable and pending continues to accumulate.
  - valid is never deasserted without a transfer.
- State machine, two states:
  - IDLE (valid=0). If pending!=0: load i=sel, clear that bit, set valid=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD (valid=1).
    - ready=0: stay in HOLD.
    - ready=1 and pending!=0: load the next sel, stay in HOLD, valid remains 1. This gives back-to-back throughput of one code per cycle.
    - ready=1 and pending==0: valid=0, go to IDLE. i keeps its last value.
- Latency: d[k] rises before edge E0, pending[k]=1 after E0, then valid=1 with i=k after E1. Minimum latency is two cycles.
- busy is combinational from registered state and has no extra latency.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined: round-robin selection.
  - Search starts at (last_loaded+1) mod N, ascending with wrap. The first set pending bit wins.
  - last_loaded is a W-bit register, reset to N-1, so the first search starts at index 0.
  - It updates on every load.
- Not defined: fixed highest-index priority as above. No last_loaded register exists.
- Handshake, latency and ovf rules are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 3 cycles with d=8'hFF, then release with d=8'hFF held -> during rst, valid=0, i=0, ovf=0, busy=0. After release, exactly 8 codes are emitted, then valid=0.
- Single pulse: d=8'h20 for one cycle, ready=1 -> two edges later valid=1, i=5 for exactly one cycle, then valid=0 and busy=0.
- Multiple events: d=8'h85 for one cycle, ready=1.
  - Fixed priority: i=7,2,0 on consecutive cycles.
  - RR_ARB_EN: i=0,2,7.
- Backpressure: ready=0 while i=2 is presented; pulse d=8'h80 -> i stays 2 and valid stays 1 until ready=1. Then 7 follows on the next cycle, and busy stays 1 throughout.
- Overflow and held input:
  - Pulse d[3] twice while ready=0 and 3 is pending -> ovf=1, and only one i=3 is emitted after ready=1.
  - Separately, hold d[1] high for 10 cycles -> exactly one i=1.
- Reset mid-HOLD: assert rst with valid=1 and two events pending -> on the next edge valid=0, busy=0 and pending is cleared. No stale codes appear after release.
